// File: rtl/banco_pkg.sv
// Shared types and default sizes for the register-file command sequencer.
//   NDef / WDef : default address width and data width
//   op_t        : command opcodes as seen on cmd_op
//   state_t     : sequencer FSM states
package banco_pkg;

  localparam int unsigned NDef = 6;
  localparam int unsigned WDef = 6;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpLoad = 3'd1,
    OpMov  = 3'd2,
    OpAdd  = 3'd3,
    OpSub  = 3'd4,
    OpAnd  = 3'd5,
    OpXor  = 3'd6,
    OpClr  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWrite,
    StClear
  } state_t;

endpackage

// File: rtl/alu_banco.sv
// Combinational ALU for the register-file sequencer.
//   op  : operation (op_t)
//   a   : rs1 read data
//   b   : rs2 read data
//   imm : immediate used by LOAD
//   y   : result, W bits, wraps modulo 2**W
module alu_banco
  import banco_pkg::*;
#(
  parameter int unsigned W = WDef
) (
  input  op_t          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] imm,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OpLoad:  y = imm;
      OpMov:   y = a;
      OpAdd:   y = a + b;
      OpSub:   y = a - b;
      OpAnd:   y = a & b;
      OpXor:   y = a ^ b;
      // NOP and CLR never use the ALU output.
      OpNop:   y = '0;
      OpClr:   y = '0;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/control_banco.sv
// Command sequencer in front of a 2-read/1-write register file.
// Accepts one command per handshake, reads sources (EXEC), writes back (WRITE),
// or sweeps every register 1..2**N-1 to zero (CLEAR).
//   clk, rst                     : clock, synchronous active-low reset
//   cmd_valid/cmd_ready          : command handshake (ready only in IDLE)
//   cmd_op/rd/rs1/rs2/imm        : command fields, captured at acceptance
//   rf_we, rf_addr_*, rf_data_in : register-file ports
//   rf_rs1, rf_rs2               : register-file read data
//   done                         : one-cycle completion pulse
//   result, zero                 : last completed value and its zero flag
module control_banco
  import banco_pkg::*;
#(
  parameter int unsigned N = NDef,
  parameter int unsigned W = WDef
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [N-1:0] cmd_rd,
  input  logic [N-1:0] cmd_rs1,
  input  logic [N-1:0] cmd_rs2,
  input  logic [W-1:0] cmd_imm,
  output logic         rf_we,
  output logic [N-1:0] rf_addr_rd,
  output logic [N-1:0] rf_addr_rs1,
  output logic [N-1:0] rf_addr_rs2,
  output logic [W-1:0] rf_data_in,
  input  logic [W-1:0] rf_rs1,
  input  logic [W-1:0] rf_rs2,
  output logic         done,
  output logic [W-1:0] result,
  output logic         zero
);

  localparam logic [N-1:0] CntLast = '1;
  localparam logic [N-1:0] CntPen  = {{(N-1){1'b1}}, 1'b0};

  state_t       state_q, state_d;
  op_t          op_q;
  logic [N-1:0] rd_q, rs1_q, rs2_q, cnt_q;
  logic [W-1:0] imm_q, alu_q, result_q, alu_y;
  logic         zero_q;
  // Holds cmd_ready low during reset and for the first cycle after release.
  logic         run_q;
  logic         accept;

  assign accept = cmd_valid && cmd_ready;

  alu_banco #(
    .W (W)
  ) u_alu (
    .op  (op_q),
    .a   (rf_rs1),
    .b   (rf_rs2),
    .imm (imm_q),
    .y   (alu_y)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (op_t'(cmd_op) == OpClr) ? StClear : StExec;
      end
      StExec:  state_d = StWrite;
      StWrite: state_d = StIdle;
      StClear: begin
        if (cnt_q == CntLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready  = 1'b0;
    rf_we      = 1'b0;
    rf_addr_rd = rd_q;
    rf_data_in = '0;
    done       = 1'b0;
    unique case (state_q)
      StIdle:  cmd_ready = run_q;
      StExec:  ;
      StWrite: begin
        rf_we      = (rd_q != '0) && (op_q != OpNop);
        rf_data_in = alu_q;
        done       = 1'b1;
      end
      StClear: begin
        rf_we      = 1'b1;
        rf_addr_rd = cnt_q;
        done       = (cnt_q == CntLast);
      end
      default: ;
    endcase
  end

  assign rf_addr_rs1 = rs1_q;
  assign rf_addr_rs2 = rs2_q;
  assign result      = result_q;
  assign zero        = zero_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q    <= 1'b0;
      op_q     <= OpNop;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      cnt_q    <= '0;
      alu_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        op_q  <= op_t'(cmd_op);
        rd_q  <= cmd_rd;
        rs1_q <= cmd_rs1;
        rs2_q <= cmd_rs2;
        imm_q <= cmd_imm;
        cnt_q <= {{(N-1){1'b0}}, 1'b1};
      end
      // result/zero are loaded one edge early so they are valid alongside done.
      if (state_q == StExec) begin
        alu_q <= alu_y;
        if (op_q != OpNop) begin
          result_q <= alu_y;
          zero_q   <= (alu_y == '0);
        end
      end
      if (state_q == StClear) begin
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CntPen) begin
          result_q <= '0;
          zero_q   <= 1'b1;
        end
      end
    end
  end

endmodule
